sum_initiator: RTL and testbench

//  Requester side of the start/valid adder protocol. Accepts operand pairs from upstream
//  on a valid/ready handshake and issues each pair to the adder as a one-cycle start pulse.

---
 rtl/sum_init_pkg.sv | 20 ++
 rtl/sum_init_wdog.sv | 31 +++
 rtl/sum_initiator.sv | 120 ++++++++++++
 tb/tb_sum_initiator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_init_pkg.sv
// Shared types and defaults for the sum_initiator requester.
// Optional result checking is enabled with SUM_INITIATOR_CHECK_EN.
package sum_init_pkg;

    localparam int unsigned TIMEOUT_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    // Counter width able to hold 0..timeout-1, never narrower than one bit.
    function automatic int unsigned wdog_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/sum_init_wdog.sv
// Wait-state watchdog: counts enabled cycles and flags the one in which the
// count would reach TIMEOUT.
module sum_init_wdog
    import sum_init_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = wdog_width(TIMEOUT);

    logic [CW-1:0] cnt_q;

    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/sum_initiator.sv
// Requester side of the start/valid adder protocol with upstream and downstream handshakes.
// Define SUM_INITIATOR_CHECK_EN to add the err_mismatch result check.
module sum_initiator
    import sum_init_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             start,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    input  logic             valid,
    input  logic [W-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             err_timeout,
    output logic             err_spur,
`ifdef SUM_INITIATOR_CHECK_EN
    output logic             err_mismatch,
`endif
    output logic [CNT_W-1:0] txn_cnt
);

    state_e state_q;
    logic   wd_clr;
    logic   wd_en;
    logic   wd_expired;

`ifdef SUM_INITIATOR_CHECK_EN
    logic [W-1:0] exp_q;
`endif

    assign in_ready = (state_q == IDLE) && rst_n;

    // The counter only advances on WAIT cycles with no response from the adder.
    assign wd_clr = (state_q == ISSUE);
    assign wd_en  = (state_q == WAIT) && !valid;

    sum_init_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start        <= 1'b0;
            a            <= '0;
            b            <= '0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            err_timeout  <= 1'b0;
            err_spur     <= 1'b0;
            txn_cnt      <= '0;
`ifdef SUM_INITIATOR_CHECK_EN
            exp_q        <= '0;
            err_mismatch <= 1'b0;
`endif
        end else begin
            start       <= 1'b0;
            err_timeout <= 1'b0;
            err_spur    <= (state_q != WAIT) && valid;
`ifdef SUM_INITIATOR_CHECK_EN
            err_mismatch <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a       <= in_a;
                        b       <= in_b;
                        start   <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SUM_INITIATOR_CHECK_EN
                    exp_q <= a + b;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A response in the terminal cycle still counts as on time.
                    if (valid) begin
                        out_sum   <= y;
                        out_valid <= 1'b1;
`ifdef SUM_INITIATOR_CHECK_EN
                        err_mismatch <= (y != exp_q);
`endif
                        state_q   <= HOLD;
                    end else if (wd_expired) begin
                        err_timeout <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        txn_cnt   <= txn_cnt + CNT_W'(1);
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_initiator.sv
// Self-checking bench for sum_initiator: table vectors, reset/spurious sequences, random traffic.
module tb_sum_initiator;

    localparam int W  = 16;
    localparam int TO = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          valid = 1'b0;
    logic [W-1:0]  y = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          err_timeout;
    logic          err_spur;
`ifdef SUM_INITIATOR_CHECK_EN
    logic          err_mismatch;
`endif
    logic [CW-1:0] txn_cnt;

    sum_initiator #(
        .W       (W),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .start        (start),
        .a            (a),
        .b            (b),
        .valid        (valid),
        .y            (y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .err_timeout  (err_timeout),
        .err_spur     (err_spur),
`ifdef SUM_INITIATOR_CHECK_EN
        .err_mismatch (err_mismatch),
`endif
        .txn_cnt      (txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ia;
        logic [W-1:0] ib;
        int           lat;     // WAIT cycle carrying the adder response; 0 = never
        logic [W-1:0] yv;      // value the adder returns
        int           stall;   // cycles out_ready is held low in HOLD
        bit           poke;    // upstream offers a new pair while busy
        logic [W-1:0] want_sum;
        bit           want_to;
        bit           want_mm;
    } vec_t;

    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_cnt = '0;
    vec_t          tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input vec_t v);
        bit hit = 1'b0;
        out_ready = (v.stall == 0);
        in_valid  = 1'b1;
        in_a      = v.ia;
        in_b      = v.ib;
        chk("idle_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("start", start, 1);
        chk("a", a, v.ia);
        chk("b", b, v.ib);
        chk("issue_in_ready", in_ready, 0);
        for (int c = 1; c <= TO; c++) begin
            tick();
            chk("wait_start", start, 0);
            chk("wait_in_ready", in_ready, 0);
            chk("wait_out_valid", out_valid, 0);
            chk("early_timeout", err_timeout, 0);
            if (v.poke) begin
                in_valid = 1'b1;
                in_a     = ~v.ia;
                in_b     = ~v.ib;
            end
            if (c == v.lat) begin
                valid = 1'b1;
                y     = v.yv;
                hit   = 1'b1;
                break;
            end
        end
        if (hit) begin
            tick();
            valid    = 1'b0;
            y        = 16'hdead;
            in_valid = 1'b0;
            chk("hold_start", start, 0);
            chk("out_valid", out_valid, 1);
            chk("out_sum", out_sum, v.want_sum);
            chk("hold_in_ready", in_ready, 0);
            chk("no_spur", err_spur, 0);
`ifdef SUM_INITIATOR_CHECK_EN
            chk("err_mismatch", err_mismatch, v.want_mm);
`endif
            for (int s = 0; s < v.stall; s++) begin
                if (s == 0 && v.stall >= 2) begin
                    valid = 1'b1;
                    y     = ~v.want_sum;
                end
                tick();
                valid = 1'b0;
                if (s == 0 && v.stall >= 2) chk("hold_spur", err_spur, 1);
`ifdef SUM_INITIATOR_CHECK_EN
                chk("mismatch_pulse", err_mismatch, 0);
`endif
                chk("stall_out_valid", out_valid, 1);
                chk("stall_out_sum", out_sum, v.want_sum);
                chk("stall_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            tick();
            exp_cnt++;
            chk("done_out_valid", out_valid, 0);
            chk("txn_cnt", txn_cnt, exp_cnt);
            chk("done_in_ready", in_ready, 1);
        end else begin
            in_valid = 1'b0;
            tick();
            chk("timeout", err_timeout, v.want_to);
            chk("to_in_ready", in_ready, 1);
            chk("to_out_valid", out_valid, 0);
            chk("to_txn_cnt", txn_cnt, exp_cnt);
            chk("to_start", start, 0);
            tick();
            chk("timeout_pulse", err_timeout, 0);
        end
    endtask

    // Async reset mid-cycle: outputs must clear before any clock edge.
    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_start"}, start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_sum"}, out_sum, 0);
        chk({tag, "_txn_cnt"}, txn_cnt, 0);
        exp_cnt   = '0;
        valid     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk({tag, "_rel_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t r;
        tbl[0] = '{16'd3,     16'd4,     1,      16'd7,     0, 1'b0, 16'd7,     1'b0, 1'b0};
        tbl[1] = '{16'h1000,  16'h0234,  1,      16'h1234,  5, 1'b1, 16'h1234,  1'b0, 1'b0};
        tbl[2] = '{16'haaaa,  16'h5555,  0,      16'h0000,  0, 1'b0, 16'h0000,  1'b1, 1'b0};
        tbl[3] = '{16'h0001,  16'h0002,  TO,     16'h0003,  1, 1'b1, 16'h0003,  1'b0, 1'b0};
        tbl[4] = '{16'h8000,  16'h8000,  3,      16'h0000,  2, 1'b0, 16'h0000,  1'b0, 1'b0};
        tbl[5] = '{16'h0010,  16'h0020,  2,      16'h0031,  0, 1'b0, 16'h0031,  1'b0, 1'b1};
        tbl[6] = '{16'hffff,  16'hffff,  TO + 1, 16'hfffe,  0, 1'b1, 16'h0000,  1'b1, 1'b0};

        #3;
        chk("rst_start", start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_spur", err_spur, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_txn_cnt", txn_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++) txn(tbl[i]);

        // Spurious response while idle.
        valid = 1'b1;
        y     = 16'h1234;
        tick();
        valid = 1'b0;
        chk("idle_spur", err_spur, 1);
        chk("idle_spur_out_valid", out_valid, 0);
        chk("idle_spur_in_ready", in_ready, 1);
        tick();
        chk("idle_spur_pulse", err_spur, 0);
        chk("idle_spur_out_sum", out_sum, 16'h0031);

        // Reset while start is high.
        in_valid = 1'b1;
        in_a     = 16'h0101;
        in_b     = 16'h0202;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_start", start, 1);
        reset_pulse("rst_issue");

        // Reset during WAIT, then a wrapping pair.
        r = '{16'h0005, 16'h0006, 1, 16'h000b, 0, 1'b0, 16'h000b, 1'b0, 1'b0};
        txn(r);
        in_valid = 1'b1;
        in_a     = 16'h0707;
        in_b     = 16'h0808;
        tick();
        in_valid = 1'b0;
        tick();
        reset_pulse("rst_wait");
        r = '{16'hffff, 16'h0001, 1, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 1'b0};
        txn(r);

        // Reset while a result is held downstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'h0005;
        in_b      = 16'h0006;
        tick();
        in_valid = 1'b0;
        tick();
        valid = 1'b1;
        y     = 16'h000b;
        tick();
        valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        reset_pulse("rst_hold");

        // Random traffic; enough completions to wrap txn_cnt.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [W-1:0] good;
            bit           bad;
            int           lat;
            ra   = W'($urandom);
            rb   = W'($urandom);
            good = ra + rb;
            bad  = ($urandom_range(0, 5) == 0);
            lat  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, TO));
            r.ia       = ra;
            r.ib       = rb;
            r.lat      = lat;
            r.yv       = bad ? good + 16'd1 : good;
            r.stall    = int'($urandom_range(0, 3));
            r.poke     = 1'($urandom_range(0, 1));
            r.want_sum = r.yv;
            r.want_to  = (lat == 0) || (lat > TO);
            r.want_mm  = (r.yv != good);
            txn(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
